// File: rtl/locked_mult_pkg.sv
// Shared types and helpers for the key-locked sequential multiplier.
package locked_mult_pkg;

   // Controller states: waiting for operands, iterating, presenting the product
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Gate polarity map shipped with the harness: 1 = OR gate, 0 = AND gate
   localparam logic [31:0] DEFAULT_KEY_TYPE = 32'hA5A5_5A5A;

   // A single key gate: OR gates pass data with key 0, AND gates with key 1
   function automatic logic gate_bit(input logic gate_type,
                                     input logic key_bit,
                                     input logic in_bit);
      return gate_type ? (in_bit | key_bit) : (in_bit & key_bit);
   endfunction

endpackage

// File: rtl/key_gate_row.sv
// Applies the key gates that belong to one shift-add step to that step's addend.
module key_gate_row
   import locked_mult_pkg::*;
#(
   parameter int                WIDTH    = 8,
   parameter int                KEY_W    = 32,
   parameter int                CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   parameter logic [KEY_W-1:0]  KEY_TYPE = KEY_W'(DEFAULT_KEY_TYPE)
) (
   input  logic [CW-1:0]        step,
   input  logic [2*WIDTH-1:0]   raw,
   input  logic [KEY_W-1:0]     key,
   output logic [2*WIDTH-1:0]   gated
);

   // Gates whose index maps to this step are chained in ascending order,
   // so a later gate on the same bit sees the output of an earlier one
   always_comb begin
      gated = raw;
      for (int j = 0; j < KEY_W; j++) begin
         if ((j % WIDTH) == int'(step)) begin
            gated[j % (2*WIDTH)] = gate_bit(KEY_TYPE[j], key[j], gated[j % (2*WIDTH)]);
         end
      end
   end

endmodule

// File: rtl/locked_seq_multiplier.sv
// Key-locked iterative shift-add unsigned multiplier with valid/ready operand
// and product handshakes and a serially loaded key register.
module locked_seq_multiplier
   import locked_mult_pkg::*;
#(
   parameter int                WIDTH    = 8,
   parameter int                KEY_W    = 32,
   parameter logic [KEY_W-1:0]  KEY_TYPE = KEY_W'(DEFAULT_KEY_TYPE)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 key_shift_i,
   input  logic                 key_bit_i,
   output logic                 key_ready_o,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     op1_i,
   input  logic [WIDTH-1:0]     op2_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [2*WIDTH-1:0]   product_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t               state;
   state_t               state_n;
   logic [KEY_W-1:0]     key_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   product_q;
   logic [WIDTH-1:0]     op1_q;
   logic [WIDTH-1:0]     op2_q;
   logic [CW-1:0]        step_cnt;
   logic [2*WIDTH-1:0]   raw_addend;
   logic [2*WIDTH-1:0]   gated_addend;
   logic [2*WIDTH-1:0]   acc_next;
   logic                 last_step;
   logic                 accept;

   // Partial product for the current multiplier bit, before key gating
   always_comb begin
      raw_addend = '0;
      if (op2_q[step_cnt]) begin
         raw_addend = {{WIDTH{1'b0}}, op1_q} << step_cnt;
      end
   end

   key_gate_row #(
      .WIDTH    (WIDTH),
      .KEY_W    (KEY_W),
      .CW       (CW),
      .KEY_TYPE (KEY_TYPE)
   ) u_key_gate_row (
      .step  (step_cnt),
      .raw   (raw_addend),
      .key   (key_q),
      .gated (gated_addend)
   );

   assign acc_next  = acc_q + gated_addend;
   assign last_step = (step_cnt == CW'(WIDTH - 1));
   assign accept    = (state == IDLE) && in_valid_i;

   // Next-state decode and handshake outputs
   always_comb begin
      state_n     = state;
      in_ready_o  = 1'b0;
      key_ready_o = 1'b0;
      out_valid_o = 1'b0;
      case (state)
         IDLE: begin
            in_ready_o  = 1'b1;
            key_ready_o = 1'b1;
            if (in_valid_i) begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (last_step) begin
               state_n = DONE;
            end
         end
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign product_o = product_q;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Key register shifts only while idle so an operation sees a frozen key
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         key_q <= '0;
      end else if ((state == IDLE) && key_shift_i) begin
         key_q <= {key_bit_i, key_q[KEY_W-1:1]};
      end
   end

   // Operand capture, accumulation and product latch; the product register
   // is only written on the final step so it holds steady outside DONE
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op1_q     <= '0;
         op2_q     <= '0;
         acc_q     <= '0;
         step_cnt  <= '0;
         product_q <= '0;
      end else if (accept) begin
         op1_q    <= op1_i;
         op2_q    <= op2_i;
         acc_q    <= '0;
         step_cnt <= '0;
      end else if (state == RUN) begin
         acc_q <= acc_next;
         if (last_step) begin
            step_cnt  <= '0;
            product_q <= acc_next;
         end else begin
            step_cnt <= step_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_locked_seq_multiplier.sv
// Self-checking bench for the key-locked sequential multiplier.
module tb_locked_seq_multiplier;

   localparam int          WIDTH    = 8;
   localparam int          KEY_W    = 32;
   localparam logic [31:0] KT       = 32'hA5A5_5A5A;
   localparam logic [31:0] GOOD_KEY = 32'h5A5A_A5A5;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        key_shift_i;
   logic        key_bit_i;
   logic        key_ready_o;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [7:0]  op1_i;
   logic [7:0]  op2_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [15:0] product_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mkey   = '0;

   locked_seq_multiplier #(
      .WIDTH    (WIDTH),
      .KEY_W    (KEY_W),
      .KEY_TYPE (KT)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .key_shift_i (key_shift_i),
      .key_bit_i   (key_bit_i),
      .key_ready_o (key_ready_o),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op1_i       (op1_i),
      .op2_i       (op2_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .product_o   (product_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: each multiplier bit contributes a shifted multiplicand, every
   // key gate j acts on bit j mod 16 of the addend of step j mod 8
   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [31:0] k);
      logic [15:0] acc;
      logic [15:0] add;
      acc = '0;
      for (int s = 0; s < 8; s++) begin
         add = b[s] ? (16'(a) << s) : 16'h0;
         for (int j = 0; j < 32; j++) begin
            if ((j % 8) == s) begin
               if (KT[j]) add[j % 16] = add[j % 16] | k[j];
               else       add[j % 16] = add[j % 16] & k[j];
            end
         end
         acc = acc + add;
      end
      return acc;
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // The first bit shifted in ends up at key[0]
   task automatic load_key(input logic [31:0] k);
      for (int i = 0; i < 32; i++) begin
         key_shift_i = 1'b1;
         key_bit_i   = k[i];
         tick();
      end
      key_shift_i = 1'b0;
      key_bit_i   = 1'b0;
      mkey        = k;
   endtask

   task automatic pulse_reset;
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      mkey   = '0;
   endtask

   // Runs one operation; reports product, latency and handshake observations
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                         input bit pulse, output logic [15:0] p, output int lat,
                         output bit stable, output bit ready_low, output bit valid_after);
      in_valid_i = 1'b1;
      op1_i      = a;
      op2_i      = b;
      tick();
      in_valid_i = 1'b0;
      op1_i      = 8'($urandom);
      op2_i      = 8'($urandom);
      lat        = 0;
      ready_low  = 1'b1;
      while (out_valid_o !== 1'b1 && lat < 40) begin
         if (in_ready_o !== 1'b0) ready_low = 1'b0;
         if (pulse) begin
            key_shift_i = 1'b1;
            key_bit_i   = 1'($urandom);
         end
         tick();
         lat++;
      end
      key_shift_i = 1'b0;
      p      = product_o;
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         tick();
         if (out_valid_o !== 1'b1 || product_o !== p) stable = 1'b0;
         if (in_ready_o !== 1'b0) ready_low = 1'b0;
      end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      valid_after = out_valid_o;
   endtask

   task automatic test_reset;
      checks++;
      if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid_o); end
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready_o); end
      checks++;
      if (key_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_key_ready got %b exp 1", key_ready_o); end
      checks++;
      if (product_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_product got %h exp 0000", product_o); end
   endtask

   task automatic test_correct_key;
      logic [15:0] p;
      int lat;
      bit stable, rl, va;
      load_key(GOOD_KEY);
      run_op(8'd13, 8'd11, 0, 1'b0, p, lat, stable, rl, va);
      checks++;
      if (lat != WIDTH) begin errors++; $display("[TB] FAIL latency got %0d exp %0d", lat, WIDTH); end
      checks++;
      if (p !== 16'h008F) begin errors++; $display("[TB] FAIL product_13x11 got %h exp 008f", p); end
      checks++;
      if (!rl) begin errors++; $display("[TB] FAIL in_ready_busy got high exp low"); end
      checks++;
      if (va !== 1'b0) begin errors++; $display("[TB] FAIL valid_drop got %b exp 0", va); end
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_done got %b exp 1", in_ready_o); end
   endtask

   task automatic test_max_hold;
      logic [15:0] p;
      int lat;
      bit stable, rl, va, extra;
      run_op(8'd255, 8'd255, 5, 1'b0, p, lat, stable, rl, va);
      checks++;
      if (p !== 16'hFE01) begin errors++; $display("[TB] FAIL product_max got %h exp fe01", p); end
      checks++;
      if (!stable) begin errors++; $display("[TB] FAIL hold_stable got unstable exp stable"); end
      checks++;
      if (!rl) begin errors++; $display("[TB] FAIL hold_in_ready got high exp low"); end
      extra = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (out_valid_o !== 1'b0) extra = 1'b1;
      end
      checks++;
      if (va !== 1'b0 || extra) begin errors++; $display("[TB] FAIL single_transfer got extra valid exp none"); end
   endtask

   task automatic test_wrong_key;
      logic [15:0] p;
      logic [7:0]  a, b;
      int lat;
      bit stable, rl, va;
      pulse_reset();
      run_op(8'd1, 8'd1, 0, 1'b0, p, lat, stable, rl, va);
      checks++;
      if (p !== 16'h0000) begin errors++; $display("[TB] FAIL zero_key_1x1 got %h exp 0000", p); end
      for (int n = 0; n < 10; n++) begin
         load_key($urandom);
         a = 8'($urandom);
         b = 8'($urandom);
         run_op(a, b, 0, 1'b0, p, lat, stable, rl, va);
         checks++;
         if (p !== model(a, b, mkey))
            begin errors++; $display("[TB] FAIL wrong_key a=%h b=%h key=%h got %h exp %h", a, b, mkey, p, model(a, b, mkey)); end
      end
   endtask

   task automatic test_shift_during_run;
      logic [15:0] p1, p2;
      logic [7:0]  a, b;
      int lat;
      bit stable, rl, va;
      for (int n = 0; n < 3; n++) begin
         load_key($urandom);
         a = 8'($urandom);
         b = 8'($urandom);
         run_op(a, b, 2, 1'b1, p1, lat, stable, rl, va);
         run_op(a, b, 0, 1'b0, p2, lat, stable, rl, va);
         checks++;
         if (p1 !== model(a, b, mkey))
            begin errors++; $display("[TB] FAIL shift_in_run got %h exp %h", p1, model(a, b, mkey)); end
         checks++;
         if (p2 !== model(a, b, mkey))
            begin errors++; $display("[TB] FAIL key_frozen got %h exp %h", p2, model(a, b, mkey)); end
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] p;
      int lat;
      bit stable, rl, va;
      load_key(GOOD_KEY);
      in_valid_i = 1'b1;
      op1_i      = 8'd13;
      op2_i      = 8'd11;
      tick();
      in_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_ni = 1'b0;
      #1;
      checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || key_ready_o !== 1'b1 || product_o !== 16'h0)
         begin errors++; $display("[TB] FAIL mid_reset got v=%b r=%b k=%b p=%h exp 0 1 1 0000", out_valid_o, in_ready_o, key_ready_o, product_o); end
      tick();
      rst_ni = 1'b1;
      mkey   = '0;
      tick();
      checks++;
      if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL aborted_output got %b exp 0", out_valid_o); end
      load_key(GOOD_KEY);
      run_op(8'd3, 8'd5, 0, 1'b0, p, lat, stable, rl, va);
      checks++;
      if (p !== 16'h000F) begin errors++; $display("[TB] FAIL after_reset_3x5 got %h exp 000f", p); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] expq[$];
      int accepts, transfers, last_acc;
      bit will_accept;
      accepts   = 0;
      transfers = 0;
      last_acc  = -1;
      op1_i       = 8'($urandom);
      op2_i       = 8'($urandom);
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      for (int c = 0; c < 60; c++) begin
         will_accept = (in_ready_o === 1'b1);
         if (will_accept) begin
            expq.push_back(16'(op1_i) * 16'(op2_i));
            if (last_acc >= 0) begin
               checks++;
               if (c - last_acc != WIDTH + 2)
                  begin errors++; $display("[TB] FAIL accept_interval got %0d exp %0d", c - last_acc, WIDTH + 2); end
            end
            last_acc = c;
            accepts++;
         end
         if (out_valid_o === 1'b1) begin
            checks++;
            if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_in_done got %b exp 0", in_ready_o); end
            checks++;
            if (expq.size() == 0) begin
               errors++; $display("[TB] FAIL b2b_spurious got product %h exp none", product_o);
            end else begin
               if (product_o !== expq[0])
                  begin errors++; $display("[TB] FAIL b2b_product got %h exp %h", product_o, expq[0]); end
               void'(expq.pop_front());
            end
            transfers++;
         end
         tick();
         if (will_accept) begin
            op1_i = 8'($urandom);
            op2_i = 8'($urandom);
         end
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      checks++;
      if (accepts != 6 || transfers != 6 || expq.size() != 0)
         begin errors++; $display("[TB] FAIL b2b_counts got acc=%0d xfer=%0d left=%0d exp 6 6 0", accepts, transfers, expq.size()); end
   endtask

   initial begin
      rst_ni      = 1'b0;
      key_shift_i = 1'b0;
      key_bit_i   = 1'b0;
      in_valid_i  = 1'b0;
      op1_i       = '0;
      op2_i       = '0;
      out_ready_i = 1'b0;
      #12;
      test_reset();
      tick();
      rst_ni = 1'b1;
      tick();
      test_correct_key();
      test_max_hold();
      test_wrong_key();
      test_shift_during_run();
      test_reset_mid();
      load_key(GOOD_KEY);
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/locked_seq_multiplier.md
Name: locked_seq_multiplier

Overview:
- Parametrised, key-locked, iterative shift-add unsigned multiplier. Successor to the combinational 8x8 AND/OR-locked multiplier.
- Operand width, key width and key-gate polarity map are parameters.
- Key is loaded serially and held in a register. Operands and result move over valid/ready handshakes.
- Sits in the locked-datapath test harness; a wrong key deterministically corrupts the product.

Parameters:
WIDTH, 8, operand width; product is 2*WIDTH bits
KEY_W, 32, number of key gates / key register bits
KEY_TYPE, 32'hA5A5_5A5A, per-gate type: 1 = OR gate (correct key bit 0), 0 = AND gate (correct key bit 1); correct key = ~KEY_TYPE

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
key_shift_i  input  1  shift one key bit in (honoured only in IDLE)
key_bit_i  input  1  serial key bit
key_ready_o  output  1  high in IDLE
in_valid_i  input  1  operand valid
in_ready_o  output  1  high in IDLE
op1_i  input  WIDTH  multiplicand
op2_i  input  WIDTH  multiplier
out_valid_o  output  1  product valid
out_ready_i  input  1  product consumed
product_o  output  2*WIDTH  product

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset: state IDLE; key register, accumulator, operand registers, step counter and product_o = 0; out_valid_o = 0; in_ready_o = key_ready_o = 1.
- Reset asserted mid-operation aborts the operation; no output is produced.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: in_valid_i & in_ready_o at an edge latches op1_i/op2_i, clears accumulator and counter, and moves to RUN.
  - RUN: one step per edge for s = 0..WIDTH-1. After the step s = WIDTH-1 edge, go to DONE. RUN lasts exactly WIDTH edges.
  - DONE: out_valid_o = 1 and product_o = accumulator, both held stable until out_ready_i is sampled high. At that edge go to IDLE; out_valid_o drops.
  - in_ready_o is low in RUN and DONE. No accept in the same cycle as the output handshake.
- Latency: out_valid_o rises WIDTH edges after the accepting edge. Throughput is one op per WIDTH+2 cycles minimum.
- Step s:
  - raw = op2[s] ? (op1 zero-extended << s) : 0, 2*WIDTH bits.
  - Key gating: for every j with (j mod WIDTH) == s, bit b = j mod (2*WIDTH) of raw is gated.
    - KEY_TYPE[j] = 0: bit = bit & key[j].
    - KEY_TYPE[j] = 1: bit = bit | key[j].
    - Multiple gates on the same bit apply in ascending j order.
  - acc <= acc + gated, modulo 2^(2*WIDTH). Wrap-around is only reachable with a wrong key.
- With correct key (~KEY_TYPE), product = op1*op2 exactly.
- Key load:
  - In IDLE, key_shift_i at an edge performs key <= {key_bit_i, key[KEY_W-1:1]}. After KEY_W shifts, the first bit shifted in sits at key[0].
  - key_shift_i in RUN/DONE is ignored; the key is frozen during an operation.
  - Shift and operand accept in the same IDLE edge: both occur, and the operation uses the post-shift key.
- No X propagation: product_o holds its last value outside DONE.

Decomposition:
- Package locked_mult_pkg:
  - state enum (IDLE, RUN, DONE)
  - function gate_bit(type, keybit, in)
  - default KEY_TYPE constant
- Sub-module key_gate_row: combinational. Given step index, raw addend, key and KEY_TYPE, returns the gated addend. Keeps the FSM/datapath file under 250 lines.

Test Plan:
- Load correct key 32'h5A5A_A5A5 (32 shifts), op1=13, op2=11 -> out_valid_o after 8 edges, product_o = 16'h008F.
- Correct key, op1=255, op2=255, out_ready_i held low 5 cycles -> product_o = 16'hFE01 stable throughout, one transfer only.
- Key left at reset (all 0), op1=1, op2=1 -> product_o = 16'h0000 (AND gate j=0 kills bit 0). Random wrong keys/operands match a bit-accurate model.
- key_shift_i pulsed during RUN -> key register unchanged; result identical to the unpulsed run.
- rst_ni asserted at step 4 of 13*11 -> all outputs return to reset values immediately; the next op 3*5 gives 16'h000F.
- Back-to-back in_valid_i held high with out_ready_i = 1 -> in_ready_o low in RUN/DONE, ops accepted every WIDTH+2 cycles, no op lost or duplicated.
